// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared Z80 bus tag codes, bridge FSM encoding and SRAM decode helper
package z80_bus_pkg;

  localparam logic [1:0] TGA_MEM = 2'b00;
  localparam logic [1:0] TGA_IO  = 2'b01;
  localparam logic [1:0] TGA_RSV = 2'b10;
  localparam logic [1:0] TGA_INT = 2'b11;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRD  = 2'd1,
    ST_EXT  = 2'd2,
    ST_ACK  = 2'd3
  } bus_state_e;

  // 17-bit compare so that aw == 16 maps the whole 64K memory space to SRAM.
  function automatic logic in_sram_window(input logic [15:0] adr, input int aw);
    logic [16:0] limit;
    limit = 17'd1 << aw;
    return ({1'b0, adr} < limit);
  endfunction

endpackage

// File: rtl/z80_bus_timeout.sv
// rtl/z80_bus_timeout.sv - loadable down-counter that parks at zero and flags expiry
module z80_bus_timeout #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/z80_mem_bridge.sv
// rtl/z80_mem_bridge.sv - Z80 core bus bridge: on-chip SRAM decode with read latency,
// external Wishbone cycles with timeout error ack and saturating error count
module z80_mem_bridge
  import z80_bus_pkg::*;
#(
  parameter int SPRAM_AW     = 15,
  parameter int SPRAM_RD_LAT = 1,
  parameter int EXT_TIMEOUT  = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [15:0]         wb_adr_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [1:0]          wb_tga_i,
  output logic [7:0]          cfg_dat_o,
  output logic                cfg_ack_o,
  output logic                cfg_err_o,
  output logic                spram_ce_o,
  output logic                spram_we_o,
  output logic [SPRAM_AW-1:0] spram_adr_o,
  input  logic [7:0]          spram_dat_i,
  output logic                ext_cyc_o,
  output logic                ext_stb_o,
  input  logic                ext_ack_i,
  input  logic [7:0]          ext_dat_i,
  output logic [7:0]          err_cnt_o
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(SPRAM_RD_LAT - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(EXT_TIMEOUT - 1);
  localparam bit               TMO_ON   = (EXT_TIMEOUT != 0);

  bus_state_e       state_q, state_d;
  logic [7:0]       dat_q, dat_d, err_cnt_q, err_cnt_d;
  logic             ack_q, ack_d, err_q, err_d, ext_q, ext_d;
  logic             req, sram_hit, cnt_load, cnt_expired;
  logic [CNT_W-1:0] cnt_load_val;

  assign req      = wb_cyc_i & wb_stb_i;
  assign sram_hit = req & (wb_tga_i == TGA_MEM) & in_sram_window(wb_adr_i, SPRAM_AW);

  z80_bus_timeout #(.W(CNT_W)) u_timeout (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .expired  (cnt_expired)
  );

  always_comb begin
    state_d      = state_q;
    dat_d        = dat_q;
    err_cnt_d    = err_cnt_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    ext_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    spram_ce_o   = 1'b0;
    spram_we_o   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sram_hit) begin
          spram_ce_o = ~wb_rst_i;
          if (wb_we_i) begin
            spram_we_o = ~wb_rst_i;
            ack_d      = 1'b1;
            state_d    = ST_ACK;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = LAT_LOAD;
            state_d      = ST_SRD;
          end
        end else if (req) begin
          ext_d        = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = TMO_LOAD;
          state_d      = ST_EXT;
        end
      end
      ST_SRD: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_expired) begin
          dat_d   = spram_dat_i;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_EXT: begin
        // An ack arriving on the expiry cycle still completes normally.
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (ext_ack_i) begin
          if (!wb_we_i) dat_d = ext_dat_i;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else if (TMO_ON && cnt_expired) begin
          if (!wb_we_i) dat_d = 8'hFF;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          state_d   = ST_ACK;
        end else begin
          ext_d = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      dat_q     <= '0;
      err_cnt_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      ext_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dat_q     <= dat_d;
      err_cnt_q <= err_cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      ext_q     <= ext_d;
    end
  end

  assign spram_adr_o = wb_adr_i[SPRAM_AW-1:0];
  assign cfg_dat_o   = dat_q;
  assign cfg_ack_o   = ack_q;
  assign cfg_err_o   = err_q;
  assign ext_cyc_o   = ext_q;
  assign ext_stb_o   = ext_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
